debug_display_scanner: RTL and testbench
========================================

# debug_display_scanner

Parametrised debug display engine that selects one of `NUM_CH` processor observation channels for the 7-segment hex display. It offers manual selection, timed auto-scan, and a snapshot buffer that freezes all channels on a capture pulse so a multi-cycle instruction can be inspected after the fact. It sits between the processor datapath/control observation buses and the hex display driver, and replaces the purely combinational display selection with a registered, clocked block.

## Interface
- `NUM_CH`, 32: number of observation channels; must be ≥2.
- `DATA_W`, 32: width of each channel and of the display word.
- `DWELL_CYCLES`, 1000: clock cycles each channel is shown in scan modes; must be ≥1.
- `ERROR_PATTERN`, 32'h0000DEDE: shown for an out-of-range select, truncated or zero-extended to `DATA_W`.
- `SEL_W` (localparam): `$clog2(NUM_CH)`.

Ports:
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Channel_Data`  in  `NUM_CH*DATA_W`  flattened channels; channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `Display_Select`  in  `SEL_W+1`  manual/freeze channel index; values ≥`NUM_CH` are invalid.
- `Mode`  in  2  00 MANUAL, 01 SCAN, 10 FREEZE, 11 FROZEN_SCAN.
- `Capture`  in  1  one-cycle pulse that loads the snapshot buffer from `Channel_Data`.
- `Step`  in  1  one-cycle pulse that advances the scan channel immediately (scan modes only).
- `HexDisplay_Out`  out  `DATA_W`  registered display word.
- `Current_Channel`  out  `SEL_W`  index of the channel driving `HexDisplay_Out`.
- `Sel_Error`  out  1  high while the displayed word is `ERROR_PATTERN`.
- `Snap_Valid`  out  1  set by the first `Capture` after reset, then sticky.
- `Value_Changed`  out  1  one-cycle pulse when the displayed word changes while `Current_Channel` is unchanged.

## Operation
- **Source selection.** Live data is `Channel_Data`. Snapshot data is a `NUM_CH×DATA_W` register array.
  - MANUAL and SCAN read live data.
  - FREEZE and FROZEN_SCAN read the snapshot array.
- **MANUAL and FREEZE.**
  - Channel is `Display_Select`.
  - If `Display_Select`≥`NUM_CH`: output is `ERROR_PATTERN`, `Sel_Error`=1, and `Current_Channel` holds its last value.
- **SCAN and FROZEN_SCAN.**
  - The dwell counter counts 0..`DWELL_CYCLES`-1.
  - At terminal count, `Current_Channel` increments, wrapping `NUM_CH`-1→0, and the dwell counter clears.
  - `Step` increments the channel and clears the dwell counter.
  - `Step` coinciding with terminal count advances the channel by exactly one.
  - `Display_Select` is ignored except on mode entry.
- **Mode entry.** Any change of `Mode` clears the dwell counter. Entering a scan mode loads `Current_Channel` from `Display_Select` if it is valid, otherwise 0.
- **Capture.**
  - Accepted in every mode. All `NUM_CH` entries load from `Channel_Data` in the same edge, and `Snap_Valid` is set.
  - If `Capture` and a mode change occur in the same cycle, the snapshot takes that cycle's inputs and the new mode takes effect in the same edge.
- **Empty snapshot.** FREEZE or FROZEN_SCAN with `Snap_Valid`=0 displays the reset contents (all zero). This is not an error.
- **Value_Changed.** Asserted when the new `HexDisplay_Out` differs from the previous one and `Current_Channel` did not change on that edge. It is never asserted on a channel switch, a mode change, or the first cycle after reset.
- **Step outside scan modes.** `Step` is ignored in MANUAL and FREEZE.

## Timing
- **Reset values.** `HexDisplay_Out`=0, `Current_Channel`=0, `Sel_Error`=0, `Snap_Valid`=0, `Value_Changed`=0, dwell counter=0, snapshot array all 0.
- **Reset mid-operation.** Reset asynchronously forces all of the above and aborts the scan in progress. A `Capture` coincident with the reset assertion is lost.
- **Latency.** One cycle: inputs sampled at edge N appear on the outputs after edge N.
- **Snapshot visibility.** A captured value is visible in FREEZE at edge N+1 after `Capture` is sampled at edge N, provided the mode is FREEZE at edge N+1.
- **Scan period.** Each channel is displayed for exactly `DWELL_CYCLES` cycles. `DWELL_CYCLES`=1 advances every cycle.
- **Handshakes.** `Capture` and `Step` are level-sampled each edge. A pulse held high for k cycles acts k times; debouncing is the caller's job.

## Test plan
- **Reset/manual.** `NUM_CH`=32. Reset, then MANUAL with `Display_Select`=5 and channel 5=32'h12345678 → `HexDisplay_Out`=32'h12345678 one cycle later, `Current_Channel`=5. Then `Display_Select`=40 → 32'h0000DEDE, `Sel_Error`=1, `Current_Channel` still 5.
- **Scan wrap.** `NUM_CH`=4, `DWELL_CYCLES`=3. Enter SCAN with `Display_Select`=2 → channels 2,2,2,3,3,3,0,0,0,1, each dwell 3 cycles. `Step` on the 2nd cycle of channel 0 → channel 1 next cycle, then dwell 3.
- **Step at terminal count.** `Step` asserted on the terminal-count cycle of channel 3 → next channel is 0, not 1.
- **Freeze.** `Capture` with channel 7=32'hAAAA0007, then change input to 32'h0, enter FREEZE with select 7 → display holds 32'hAAAA0007 and `Snap_Valid`=1. FREEZE before any capture → display 0.
- **Value_Changed.** MANUAL on channel 3, input 1→2 → `Value_Changed` pulses once. Switching select 3→4 → no pulse.
- **Async reset.** Assert `Reset_n`=0 mid-dwell in FROZEN_SCAN → all outputs 0 immediately without a clock edge, and the snapshot is cleared.

Source files
------------

// File: rtl/debug_display_scanner.sv
// debug_display_scanner
// Registered channel selector for the hex debug display. Picks one of NUM_CH
// observation channels either by hand (MANUAL), by timed rotation (SCAN), or
// from a snapshot taken on a Capture pulse (FREEZE / FROZEN_SCAN). This lets a
// multi-cycle instruction be inspected after the fact.
//
// Ports:
//   Clock           rising-edge system clock
//   Reset_n         asynchronous active-low reset
//   Channel_Data    flattened live channels, channel k at [k*DATA_W +: DATA_W]
//   Display_Select  manual/freeze channel index (>= NUM_CH is invalid)
//   Mode            00 MANUAL, 01 SCAN, 10 FREEZE, 11 FROZEN_SCAN
//   Capture         loads the snapshot array from Channel_Data (per cycle high)
//   Step            advances the scan channel immediately (scan modes only)
//   HexDisplay_Out  registered display word
//   Current_Channel channel index driving HexDisplay_Out
//   Sel_Error       high while ERROR_PATTERN is displayed
//   Snap_Valid      sticky flag, set by the first Capture after reset
//   Value_Changed   one-cycle pulse: word changed on an unchanged channel
module debug_display_scanner #(
    parameter int          NUM_CH        = 32,
    parameter int          DATA_W        = 32,
    parameter int          DWELL_CYCLES  = 1000,
    parameter logic [31:0] ERROR_PATTERN = 32'h0000DEDE,
    localparam int         SEL_W         = $clog2(NUM_CH)
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic [NUM_CH*DATA_W-1:0] Channel_Data,
    input  logic [SEL_W:0]           Display_Select,
    input  logic [1:0]               Mode,
    input  logic                     Capture,
    input  logic                     Step,
    output logic [DATA_W-1:0]        HexDisplay_Out,
    output logic [SEL_W-1:0]         Current_Channel,
    output logic                     Sel_Error,
    output logic                     Snap_Valid,
    output logic                     Value_Changed
);

    // Mode encoding: bit 0 selects scanning, bit 1 selects the snapshot source.
    typedef enum logic [1:0] {
        MODE_MANUAL      = 2'b00,
        MODE_SCAN        = 2'b01,
        MODE_FREEZE      = 2'b10,
        MODE_FROZEN_SCAN = 2'b11
    } mode_e;

    localparam int                 DWELL_W    = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0]   CH_LAST    = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W:0]     CH_COUNT   = (SEL_W + 1)'(NUM_CH);
    localparam logic [DATA_W-1:0]  ERR_WORD   = DATA_W'(ERROR_PATTERN);

    logic [DATA_W-1:0]  snap [NUM_CH];
    logic [DWELL_W-1:0] dwell;
    mode_e              mode_q;
    logic               started;   // suppresses Value_Changed on the first edge after reset

    logic               sel_ok;
    logic [SEL_W-1:0]   sel_idx;
    logic               mode_chg;
    logic [SEL_W-1:0]   ch_nx;
    logic [DWELL_W-1:0] dwell_nx;
    logic               err_nx;
    logic [DATA_W-1:0]  word_nx;
    logic [DATA_W-1:0]  out_nx;
    logic               vc_nx;

    always_comb begin
        sel_ok   = (Display_Select < CH_COUNT);
        sel_idx  = Display_Select[SEL_W-1:0];
        mode_chg = (Mode != mode_q);
        ch_nx    = Current_Channel;
        dwell_nx = '0;
        err_nx   = 1'b0;

        if (Mode[0]) begin
            // Scan modes: select is only honoured on entry; Step and terminal
            // count share one increment so together they advance by one.
            if (mode_chg) begin
                ch_nx = sel_ok ? sel_idx : '0;
            end else if (Step || (dwell == DWELL_LAST)) begin
                ch_nx = (Current_Channel == CH_LAST) ? '0 : Current_Channel + 1'b1;
            end else begin
                dwell_nx = dwell + 1'b1;
            end
        end else if (sel_ok) begin
            ch_nx = sel_idx;
        end else begin
            // Invalid select keeps the last good channel index on display.
            err_nx = 1'b1;
        end

        word_nx = Mode[1] ? snap[ch_nx] : Channel_Data[int'(ch_nx)*DATA_W +: DATA_W];
        out_nx  = err_nx ? ERR_WORD : word_nx;
        vc_nx   = started && !mode_chg && (ch_nx == Current_Channel) && (out_nx != HexDisplay_Out);
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap[k] <= '0;
            end
            Snap_Valid      <= 1'b0;
            dwell           <= '0;
            mode_q          <= MODE_MANUAL;
            started         <= 1'b0;
            Current_Channel <= '0;
            HexDisplay_Out  <= '0;
            Sel_Error       <= 1'b0;
            Value_Changed   <= 1'b0;
        end else begin
            if (Capture) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    snap[k] <= Channel_Data[k*DATA_W +: DATA_W];
                end
                Snap_Valid <= 1'b1;
            end
            dwell           <= dwell_nx;
            mode_q          <= mode_e'(Mode);
            started         <= 1'b1;
            Current_Channel <= ch_nx;
            HexDisplay_Out  <= out_nx;
            Sel_Error       <= err_nx;
            Value_Changed   <= vc_nx;
        end
    end

endmodule

// File: tb/tb_debug_display_scanner.sv
// Testbench for debug_display_scanner. Two instances: a 32-channel one for
// manual/freeze/Value_Changed behaviour and a 4-channel, 3-cycle-dwell one for
// scan rotation, Step handling, frozen scan and asynchronous reset.
// Expected results are queued when stimulus is driven and checked after the
// following rising edge.
module tb_debug_display_scanner;

    logic clk;
    logic rst_n;

    // 32-channel instance
    logic [32*32-1:0] a_data;
    logic [5:0]       a_sel;
    logic [1:0]       a_mode;
    logic             a_cap, a_step;
    logic [31:0]      a_out;
    logic [4:0]       a_ch;
    logic             a_err, a_sv, a_vc;

    // 4-channel, dwell-3 instance
    logic [4*32-1:0]  b_data;
    logic [2:0]       b_sel;
    logic [1:0]       b_mode;
    logic             b_cap, b_step;
    logic [31:0]      b_out;
    logic [1:0]       b_ch;
    logic             b_err, b_sv, b_vc;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        bit          is_b;
        logic [31:0] out;
        logic [31:0] ch;
        logic        err;
        logic        sv;
        int          vc;     // -1: not compared
    } exp_t;

    exp_t sbq[$];

    int scan_ch   [24] = '{2,2,2,3,3,3,0,0,0,1,1,1,2,2,2,3,3,3,0,0,1,1,1,2};
    int scan_step [24] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1,0,1,0,0,0};

    debug_display_scanner #(
        .NUM_CH(32), .DATA_W(32), .DWELL_CYCLES(1000), .ERROR_PATTERN(32'h0000DEDE)
    ) dut_a (
        .Clock(clk), .Reset_n(rst_n), .Channel_Data(a_data), .Display_Select(a_sel),
        .Mode(a_mode), .Capture(a_cap), .Step(a_step), .HexDisplay_Out(a_out),
        .Current_Channel(a_ch), .Sel_Error(a_err), .Snap_Valid(a_sv), .Value_Changed(a_vc)
    );

    debug_display_scanner #(
        .NUM_CH(4), .DATA_W(32), .DWELL_CYCLES(3), .ERROR_PATTERN(32'h0000DEDE)
    ) dut_b (
        .Clock(clk), .Reset_n(rst_n), .Channel_Data(b_data), .Display_Select(b_sel),
        .Mode(b_mode), .Capture(b_cap), .Step(b_step), .HexDisplay_Out(b_out),
        .Current_Channel(b_ch), .Sel_Error(b_err), .Snap_Valid(b_sv), .Value_Changed(b_vc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic push(input string tag, input bit is_b, input logic [31:0] out, input int ch,
                        input bit err, input bit sv, input int vc);
        exp_t e;
        e.tag = tag; e.is_b = is_b; e.out = out; e.ch = 32'(ch);
        e.err = err; e.sv = sv; e.vc = vc;
        sbq.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.is_b) begin
                cmp(e.tag, "out", b_out, e.out);
                cmp(e.tag, "ch",  32'(b_ch), e.ch);
                cmp(e.tag, "err", 32'(b_err), 32'(e.err));
                cmp(e.tag, "sv",  32'(b_sv), 32'(e.sv));
                if (e.vc >= 0) cmp(e.tag, "vc", 32'(b_vc), 32'(e.vc));
            end else begin
                cmp(e.tag, "out", a_out, e.out);
                cmp(e.tag, "ch",  32'(a_ch), e.ch);
                cmp(e.tag, "err", 32'(a_err), 32'(e.err));
                cmp(e.tag, "sv",  32'(a_sv), 32'(e.sv));
                if (e.vc >= 0) cmp(e.tag, "vc", 32'(a_vc), 32'(e.vc));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_a"}, "out", a_out, 32'h0);
        cmp({tag, "_a"}, "ch",  32'(a_ch), 32'h0);
        cmp({tag, "_a"}, "err", 32'(a_err), 32'h0);
        cmp({tag, "_a"}, "sv",  32'(a_sv), 32'h0);
        cmp({tag, "_a"}, "vc",  32'(a_vc), 32'h0);
        cmp({tag, "_b"}, "out", b_out, 32'h0);
        cmp({tag, "_b"}, "ch",  32'(b_ch), 32'h0);
        cmp({tag, "_b"}, "err", 32'(b_err), 32'h0);
        cmp({tag, "_b"}, "sv",  32'(b_sv), 32'h0);
        cmp({tag, "_b"}, "vc",  32'(b_vc), 32'h0);
    endtask

    initial begin
        rst_n  = 1'b0;
        a_data = '0; a_sel = '0; a_mode = 2'b00; a_cap = 1'b0; a_step = 1'b0;
        b_data = '0; b_sel = '0; b_mode = 2'b00; b_cap = 1'b0; b_step = 1'b0;
        for (int k = 0; k < 4; k++) b_data[k*32 +: 32] = 32'hB0 + 32'(k);

        #2;
        check_all_zero("reset");
        #10;
        rst_n = 1'b1;

        // Manual selection and invalid select
        a_data[5*32 +: 32] = 32'h12345678;
        a_sel = 6'd5;
        push("man5", 0, 32'h12345678, 5, 0, 0, 0);
        tick();
        a_sel = 6'd40;
        push("selerr", 0, 32'h0000DEDE, 5, 1, 0, -1);
        tick();

        // Value_Changed; Step is ignored in MANUAL
        a_sel = 6'd3;
        a_data[3*32 +: 32] = 32'd1;
        push("vc_a", 0, 32'd1, 3, 0, 0, 0);
        tick();
        a_data[3*32 +: 32] = 32'd2;
        a_step = 1'b1;
        push("vc_b", 0, 32'd2, 3, 0, 0, 1);
        tick();
        a_step = 1'b0;
        push("vc_c", 0, 32'd2, 3, 0, 0, 0);
        tick();
        a_sel = 6'd4;
        a_data[4*32 +: 32] = 32'h44;
        push("vc_sw", 0, 32'h44, 4, 0, 0, 0);
        tick();

        // Freeze: empty snapshot, capture, visibility one edge later
        a_data[7*32 +: 32] = 32'hBBBB0007;
        a_mode = 2'b10;
        a_sel  = 6'd7;
        push("frz_empty", 0, 32'h0, 7, 0, 0, 0);
        tick();
        a_data[7*32 +: 32] = 32'hAAAA0007;
        a_cap = 1'b1;
        push("frz_cap", 0, 32'h0, 7, 0, 1, 0);
        tick();
        a_cap = 1'b0;
        a_data[7*32 +: 32] = 32'h0;
        push("frz_show", 0, 32'hAAAA0007, 7, 0, 1, 1);
        tick();
        a_mode = 2'b00;
        push("man7", 0, 32'h0, 7, 0, 1, 0);
        tick();
        a_mode = 2'b10;
        push("frz_reentry", 0, 32'hAAAA0007, 7, 0, 1, 0);
        tick();
        a_data[7*32 +: 32] = 32'h55;
        push("frz_hold", 0, 32'hAAAA0007, 7, 0, 1, 0);
        tick();
        a_sel = 6'd32;
        push("frz_err", 0, 32'h0000DEDE, 7, 1, 1, -1);
        tick();
        a_mode = 2'b00;
        a_sel  = 6'd0;

        // Scan rotation, wrap, Step at terminal count and mid-dwell
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin
                b_mode = 2'b01;
                b_sel  = 3'd2;
            end
            if (i == 1) b_sel = 3'd3;
            b_step = scan_step[i][0];
            push($sformatf("scan%0d", i), 1, 32'hB0 + 32'(scan_ch[i]), scan_ch[i], 0, 0, 0);
            tick();
        end
        b_step = 1'b0;

        // Capture during SCAN, then frozen scan from the snapshot
        for (int k = 0; k < 4; k++) b_data[k*32 +: 32] = 32'hC0 + 32'(k);
        b_cap = 1'b1;
        push("bcap", 1, 32'hC2, 2, 0, 1, 1);
        tick();
        b_cap  = 1'b0;
        b_data = '0;
        b_mode = 2'b11;
        b_sel  = 3'd1;
        push("fscan_in", 1, 32'hC1, 1, 0, 1, 0);
        tick();
        push("fscan_hold", 1, 32'hC1, 1, 0, 1, 0);
        tick();

        // Asynchronous reset mid-dwell, no clock edge in between
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        #3;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) b_data[k*32 +: 32] = 32'hD0 + 32'(k);
        push("post_rst_b", 1, 32'h0, 1, 0, 0, 0);
        push("post_rst_a", 0, 32'h0, 0, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
